dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Multi-cycle sequencer between the pipeline's memory stage and the byte-wide data memory. It accepts one load/store request at a time (byte, halfword or word, big-endian) and issues the byte accesses to the 8-bit memory array. For loads it assembles and sign/zero-extends the result. It also drives the write-back select that chooses between the loaded data and the zero-extended 8-bit address.

## Interface
- `ADDR_W`, 8, byte-address width of the data memory.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request strobe; sampled only in IDLE.
- `rw` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 halfword, 10 word; 11 treated as misaligned (err).
- `signed_ld` in 1: 1 = sign-extend loads, 0 = zero-extend.
- `addr` in ADDR_W: base byte address.
- `wdata` in 32: store data, right-justified for byte/halfword.
- `mem_rdata` in 8: memory read byte, valid the cycle after `mem_addr` is driven.
- `mem_addr` out ADDR_W: memory byte address.
- `mem_we` out 1: memory byte write enable.
- `mem_wdata` out 8: memory write byte.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: high with `done` for a misaligned or illegal-size request.
- `rdata` out 32: extended load result; held until the next accept.
- `wb_sel` out 1: write-back mux select; 1 = `rdata`, 0 = {24'b0, addr}.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **Accept:** in IDLE with `start`=1, latch `rw`, `size`, `signed_ld`, `addr` and `wdata`. Then:
  - clear the shift register and `wb_sel`;
  - set N = 1/2/4 by `size`;
  - set cnt = 0.
- **Alignment:** a halfword needs addr[0]=0 and a word needs addr[1:0]=00; size 11 is illegal. A failing request goes IDLE→DONE with `err`=1 and no memory cycle (`mem_we` stays 0).
- **RUN:** one byte per cycle for cnt = 0..N-1.
  - `mem_addr` = base + cnt, modulo 2^ADDR_W. Aligned accesses never wrap.
  - `mem_we` = `rw`.
  - Byte order is big-endian: byte cnt is the most-significant remaining byte. Word order is [31:24],[23:16],[15:8],[7:0]; halfword is [15:8],[7:0]; byte is [7:0].
  - When cnt = N-1, go to DRAIN for a load or DONE for a store.
- **Load capture:** in each cycle after an issued read byte (RUN cycles 2..N and DRAIN), shift = {shift[23:0], mem_rdata}.
- **DRAIN** (loads only): captures the last byte, then goes to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE. For a successful load:
  - `rdata` = shift extended from bit 7 (byte) or bit 15 (halfword) according to `signed_ld`;
  - `wb_sel` goes to 1 and stays 1 until the next accept.
- **Output hold:** stores and errors leave `rdata` unchanged and `wb_sel`=0.
- **Busy requests:** `start` while busy is ignored and not queued. A new request can be accepted on the first IDLE cycle after DONE.
- **Reset:** `reset` at any time, including mid-RUN, forces IDLE on that edge.
  - All outputs go to 0: `mem_addr`, `mem_we`, `mem_wdata`, `busy`, `done`, `err`, `rdata`, `wb_sel`.
  - Bytes already written stay in memory.
  - `done` does not pulse for the aborted request.

## Timing
- The accept edge is cycle 0; RUN occupies cycles 1..N.
- Store: `done` in cycle N+1 (byte 2, half 3, word 5).
- Load: DRAIN in cycle N+1; `done` and valid `rdata` in cycle N+2 (byte 3, half 4, word 6).
- Error: `done`/`err` in cycle 1.
- All outputs are registered. `mem_*` change only on clock edges.
- `busy` is 1 from cycle 1 through the DONE cycle inclusive.

## Test plan
- Store then load a word at 0x10 with `wdata`=0xA1B2C3D4.
  - Store: `mem_we`=1 in cycles 1–4 with addr/data 10/A1, 11/B2, 12/C3, 13/D4; `done` in cycle 5.
  - Load: `done` in cycle 6 with `rdata`=0xA1B2C3D4 and `wb_sel`=1.
- Byte at 0x20 holding 0x80:
  - `signed_ld`=1 gives 0xFFFFFF80;
  - `signed_ld`=0 gives 0x00000080;
  - `done` in cycle 3 in both cases.
- Halfword at 0x30 holding 80,01:
  - signed gives 0xFFFF8001, unsigned gives 0x00008001;
  - a halfword request at 0x31 gives `err`=`done`=1 in cycle 1, `mem_we` never asserted, `rdata` unchanged;
  - a size=11 request gives the same error response.
- Hold `start`=1 continuously through a word store: exactly 4 memory writes; the next accept occurs in cycle 6 (the IDLE cycle after DONE).
- Word load at 0xFC: addresses FC, FD, FE, FF with no wrap; the result is correct.
- Assert `reset` in cycle 2 of a word store:
  - only byte 0x10 is written;
  - all outputs are 0 in the next cycle;
  - `done` never pulses;
  - a subsequent request behaves normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences one byte/halfword/word load or store at a time
// onto a byte-wide data memory. Loads are big-endian and are sign- or
// zero-extended. wb_sel chooses between rdata and the zero-extended address.
module dmem_access_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              signed_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              wb_sel
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q;
  logic              rw_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [1:0]        last_q;   // index of final byte: N-1
  logic [1:0]        cnt_q;
  logic [23:0]       shift_q;  // earlier bytes of a load; last byte comes straight from mem_rdata

  logic              misaligned;
  logic [1:0]        last_in;
  logic [1:0]        cnt_inc;
  logic [7:0]        first_byte;
  logic [7:0]        next_byte;
  logic [31:0]       load_word;
  logic [31:0]       ext_word;

  // Byte idx counted from the least-significant end of the store word.
  function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return b;
  endfunction

  // Request decode, next-byte selection and load extension.
  always_comb begin
    misaligned = (size == 2'b11)
               | ((size == 2'b01) & addr[0])
               | ((size == 2'b10) & (addr[1:0] != 2'b00));
    case (size)
      2'b00:   last_in = 2'd0;
      2'b01:   last_in = 2'd1;
      default: last_in = 2'd3;
    endcase
    cnt_inc    = cnt_q + 2'd1;
    // Byte cnt is the most-significant remaining one: index last - cnt.
    first_byte = byte_of(wdata, last_in);
    next_byte  = byte_of(wdata_q, last_q - cnt_inc);
    load_word  = {shift_q, mem_rdata};
    case (size_q)
      2'b00:   ext_word = sgn_q ? {{24{load_word[7]}}, load_word[7:0]}
                                : {24'b0, load_word[7:0]};
      2'b01:   ext_word = sgn_q ? {{16{load_word[15]}}, load_word[15:0]}
                                : {16'b0, load_word[15:0]};
      default: ext_word = load_word;
    endcase
  end

  // Sequencer state, memory-side outputs and load result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rw_q      <= 1'b0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      wb_sel    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rw_q    <= rw;
            size_q  <= size;
            sgn_q   <= signed_ld;
            base_q  <= addr;
            wdata_q <= wdata;
            last_q  <= last_in;
            cnt_q   <= '0;
            shift_q <= '0;
            wb_sel  <= 1'b0;
            busy    <= 1'b1;
            if (misaligned) begin
              state_q <= DONE;
              done    <= 1'b1;
              err     <= 1'b1;
            end else begin
              // First byte is issued on the accept edge so RUN starts with it on the bus.
              state_q   <= RUN;
              mem_addr  <= addr;
              mem_we    <= rw;
              mem_wdata <= first_byte;
            end
          end
        end
        RUN: begin
          // Read data for the byte issued last cycle is present now.
          if (!rw_q && (cnt_q != 2'd0)) begin
            shift_q <= {shift_q[15:0], mem_rdata};
          end
          if (cnt_q == last_q) begin
            mem_we <= 1'b0;
            if (rw_q) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            cnt_q     <= cnt_inc;
            mem_addr  <= base_q + ADDR_W'(cnt_inc);
            mem_wdata <= next_byte;
          end
        end
        DRAIN: begin
          rdata   <= ext_word;
          wb_sel  <= 1'b1;
          done    <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          done    <= 1'b0;
          err     <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: fixed vector table, randomized
// requests against a byte-array reference model, and multi-cycle sequences
// for held start and mid-transfer reset.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rw;
  logic [1:0]  size;
  logic        signed_ld;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        wb_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rw        (rw),
    .size      (size),
    .signed_ld (signed_ld),
    .addr      (addr),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .wb_sel    (wb_sel)
  );

  // Byte-wide synchronous memory; read data appears the cycle after the address.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  // Log of every memory write as {addr, data}.
  logic [15:0] wlog [4096];
  int          wr_total = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      wlog[wr_total & 4095] <= {mem_addr, mem_wdata};
      wr_total <= wr_total + 1;
    end
  end

  // Reference model state.
  logic [7:0]  refmem [256];
  logic [31:0] m_rdata = '0;

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sgn;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_wb;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic is_bad(input logic [1:0] sz, input logic [7:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  // Reference: predicts outcome of one request and updates model state.
  task automatic model_exp(input logic r, input logic [1:0] sz, input logic sg,
                           input logic [7:0] a, input logic [31:0] wd,
                           output logic e, output int lat, output logic [31:0] rd,
                           output logic wb);
    int n;
    logic [31:0] val;
    logic [7:0]  ai;
    n = nbytes(sz);
    if (is_bad(sz, a)) begin
      e = 1'b1; lat = 1; rd = m_rdata; wb = 1'b0;
    end else if (r) begin
      for (int i = 0; i < n; i++) begin
        ai = a + 8'(i);
        refmem[ai] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
      end
      e = 1'b0; lat = n + 1; rd = m_rdata; wb = 1'b0;
    end else begin
      val = 0;
      for (int i = 0; i < n; i++) begin
        ai = a + 8'(i);
        val = (val << 8) | 32'(refmem[ai]);
      end
      if (sg && n == 1 && val >= 32'h80)   val = val | 32'hFFFFFF00;
      if (sg && n == 2 && val >= 32'h8000) val = val | 32'hFFFF0000;
      m_rdata = val;
      e = 1'b0; lat = n + 2; rd = val; wb = 1'b1;
    end
  endtask

  // Drive one request and observe the response cycle by cycle after the accept edge.
  task automatic run_req(input logic r, input logic [1:0] sz, input logic sg,
                         input logic [7:0] a, input logic [31:0] wd,
                         output int lat, output logic e, output logic [31:0] rd,
                         output logic wb, output logic bsy_ok, output logic post_ok,
                         output int w0);
    @(negedge clk);
    w0 = wr_total;
    rw = r; size = sz; signed_ld = sg; addr = a; wdata = wd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; e = 1'b0; rd = '0; wb = 1'b0; bsy_ok = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!busy) bsy_ok = 1'b0;
      if (done) begin
        lat = k; e = err; rd = rdata; wb = wb_sel;
        break;
      end
    end
    @(negedge clk);
    post_ok = !done && !busy;
  endtask

  task automatic check_req(input string tag, input logic r, input logic [1:0] sz,
                           input logic sg, input logic [7:0] a, input logic [31:0] wd,
                           input logic exp_err, input int exp_lat,
                           input logic [31:0] exp_rd, input logic exp_wb);
    int lat, w0, n;
    logic e, wb, bsy_ok, post_ok;
    logic [31:0] rd;
    logic [7:0] ai;
    run_req(r, sz, sg, a, wd, lat, e, rd, wb, bsy_ok, post_ok, w0);
    chk($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s err", tag), {31'b0, e}, {31'b0, exp_err});
    chk($sformatf("%s rdata", tag), rd, exp_rd);
    chk($sformatf("%s wb_sel", tag), {31'b0, wb}, {31'b0, exp_wb});
    chk($sformatf("%s busy_during", tag), {31'b0, bsy_ok}, 32'd1);
    chk($sformatf("%s idle_after", tag), {31'b0, post_ok}, 32'd1);
    n = (!exp_err && r) ? nbytes(sz) : 0;
    chk($sformatf("%s wr_count", tag), 32'(wr_total - w0), 32'(n));
    for (int i = 0; i < n; i++) begin
      ai = a + 8'(i);
      chk($sformatf("%s wr_byte%0d", tag, i), {16'b0, wlog[(w0 + i) & 4095]},
          {16'b0, ai, 8'((wd >> (8 * (n - 1 - i))) & 32'hFF)});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        r, sg, e, wb, done_seen;
    logic [1:0]  sz;
    logic [7:0]  a;
    logic [31:0] wd, rd;
    int          lat, w0, done_cyc;

    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i * 7 + 3);
      refmem[i] = 8'(i * 7 + 3);
    end

    //         rw    size  sgn   addr   wdata          err   lat rdata          wb
    vt[0]  = '{1'b1, 2'd2, 1'b0, 8'h10, 32'hA1B2C3D4, 1'b0, 5, 32'h00000000, 1'b0};
    vt[1]  = '{1'b0, 2'd2, 1'b0, 8'h10, 32'h0,        1'b0, 6, 32'hA1B2C3D4, 1'b1};
    vt[2]  = '{1'b1, 2'd0, 1'b0, 8'h20, 32'h00000080, 1'b0, 2, 32'hA1B2C3D4, 1'b0};
    vt[3]  = '{1'b0, 2'd0, 1'b1, 8'h20, 32'h0,        1'b0, 3, 32'hFFFFFF80, 1'b1};
    vt[4]  = '{1'b0, 2'd0, 1'b0, 8'h20, 32'h0,        1'b0, 3, 32'h00000080, 1'b1};
    vt[5]  = '{1'b1, 2'd1, 1'b0, 8'h30, 32'h00008001, 1'b0, 3, 32'h00000080, 1'b0};
    vt[6]  = '{1'b0, 2'd1, 1'b1, 8'h30, 32'h0,        1'b0, 4, 32'hFFFF8001, 1'b1};
    vt[7]  = '{1'b0, 2'd1, 1'b0, 8'h30, 32'h0,        1'b0, 4, 32'h00008001, 1'b1};
    vt[8]  = '{1'b0, 2'd1, 1'b0, 8'h31, 32'h0,        1'b1, 1, 32'h00008001, 1'b0};
    vt[9]  = '{1'b0, 2'd3, 1'b0, 8'h30, 32'h0,        1'b1, 1, 32'h00008001, 1'b0};
    vt[10] = '{1'b1, 2'd2, 1'b0, 8'hFC, 32'h11223344, 1'b0, 5, 32'h00008001, 1'b0};
    vt[11] = '{1'b0, 2'd2, 1'b1, 8'hFC, 32'h0,        1'b0, 6, 32'h11223344, 1'b1};
    vt[12] = '{1'b1, 2'd2, 1'b0, 8'h12, 32'hCAFEF00D, 1'b1, 1, 32'h11223344, 1'b0};

    reset = 1'b1; start = 1'b0; rw = 1'b0; size = '0; signed_ld = 1'b0;
    addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done_err_we", {29'b0, done, err, mem_we}, 32'd0);
    chk("reset mem_addr_wdata", {16'b0, mem_addr, mem_wdata}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset wb_sel", {31'b0, wb_sel}, 32'd0);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      model_exp(vt[i].rw, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata, e, lat, rd, wb);
      check_req($sformatf("vec%0d", i), vt[i].rw, vt[i].size, vt[i].sgn, vt[i].addr,
                vt[i].wdata, vt[i].exp_err, vt[i].exp_lat, vt[i].exp_rdata, vt[i].exp_wb);
    end

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      r  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      wd = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & 8'hFE;
        if (sz == 2'd2) a = a & 8'hFC;
      end
      model_exp(r, sz, sg, a, wd, e, lat, rd, wb);
      check_req($sformatf("rnd%0d", i), r, sz, sg, a, wd, e, lat, rd, wb);
    end

    // start held high through a word store: second accept on the IDLE cycle after DONE.
    @(negedge clk);
    w0 = wr_total;
    rw = 1'b1; size = 2'd2; signed_ld = 1'b0; addr = 8'h40; wdata = 32'hDEADBEEF;
    start = 1'b1;
    @(posedge clk);
    done_cyc = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done && done_cyc < 0) done_cyc = k;
    end
    chk("held done_cycle", 32'(done_cyc), 32'd5);
    chk("held idle_cycle6", {31'b0, busy}, 32'd0);
    chk("held wr_count", 32'(wr_total - w0), 32'd4);
    @(negedge clk);
    chk("held reaccept", {30'b0, busy, mem_we}, 32'd3);
    start = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 10 && !done_seen; k++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("held second_done", {31'b0, done_seen}, 32'd1);
    @(negedge clk);
    chk("held total_writes", 32'(wr_total - w0), 32'd8);
    model_exp(1'b1, 2'd2, 1'b0, 8'h40, 32'hDEADBEEF, e, lat, rd, wb);
    model_exp(1'b1, 2'd2, 1'b0, 8'h40, 32'hDEADBEEF, e, lat, rd, wb);
    model_exp(1'b0, 2'd2, 1'b0, 8'h40, 32'h0, e, lat, rd, wb);
    check_req("held readback", 1'b0, 2'd2, 1'b0, 8'h40, 32'h0, e, lat, rd, wb);

    // Reset during a word store: only the first byte lands, no done pulse.
    @(negedge clk);
    w0 = wr_total;
    rw = 1'b1; size = 2'd2; signed_ld = 1'b0; addr = 8'h10; wdata = 32'h55667788;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy_done_err", {29'b0, busy, done, err}, 32'd0);
    chk("abort mem_we", {31'b0, mem_we}, 32'd0);
    chk("abort mem_addr_wdata", {16'b0, mem_addr, mem_wdata}, 32'd0);
    chk("abort rdata_wb", {rdata[30:0], wb_sel} | {31'b0, rdata[31]}, 32'd0);
    reset = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("abort no_done", {31'b0, done_seen}, 32'd0);
    chk("abort wr_count", 32'(wr_total - w0), 32'd1);
    chk("abort wr_byte", {16'b0, wlog[w0 & 4095]}, 32'h00001055);
    refmem[8'h10] = 8'h55;
    m_rdata = '0;
    model_exp(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, e, lat, rd, wb);
    check_req("abort after", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, e, lat, rd, wb);
    model_exp(1'b0, 2'd0, 1'b1, 8'h11, 32'h0, e, lat, rd, wb);
    check_req("abort after_b", 1'b0, 2'd0, 1'b1, 8'h11, 32'h0, e, lat, rd, wb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
